// File: rtl/csr_file_pkg.sv
// Shared machine-mode CSR types, addresses, masks and read helpers.
package csr_file_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_t;

    localparam logic [11:0] CSR_SATP     = 12'h180;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // mie(3), mpie(7), mpp(12:11), sum(18), mxr(19), tvm(20)
    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_001C_1888;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

    localparam int unsigned IRQ_MEI = 11;
    localparam int unsigned IRQ_MTI = 7;
    localparam int unsigned IRQ_MSI = 3;

    typedef struct packed {
        logic [63:21] rsv_hi;
        logic         tvm;
        logic         mxr;
        logic         sum;
        logic [17:13] rsv_13;
        logic [1:0]   mpp;
        logic [10:8]  rsv_8;
        logic         mpie;
        logic [6:4]   rsv_4;
        logic         mie;
        logic [2:0]   rsv_0;
    } mstatus_t;

    typedef struct packed {
        mstatus_t    mstatus;
        logic [63:0] mie;
        logic [63:0] mip;
        logic [63:0] mtvec;
        logic [63:0] mscratch;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic [63:0] satp;
        logic [63:0] mcycle;
        logic [63:0] mhartid;
    } csr_regs_t;

    function automatic logic csr_implemented(input logic [11:0] a);
        case (a)
            CSR_SATP, CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MHARTID: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] csr_read(input csr_regs_t r, input logic [11:0] a);
        case (a)
            CSR_SATP:     return r.satp;
            CSR_MSTATUS:  return r.mstatus;
            CSR_MIE:      return r.mie;
            CSR_MTVEC:    return r.mtvec;
            CSR_MSCRATCH: return r.mscratch;
            CSR_MEPC:     return r.mepc;
            CSR_MCAUSE:   return r.mcause;
            CSR_MTVAL:    return r.mtval;
            CSR_MIP:      return r.mip;
            CSR_MCYCLE:   return r.mcycle;
            CSR_MHARTID:  return r.mhartid;
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_trap_target.sv
// Combinational redirect target for trap entry (direct/vectored) and mret.
module csr_trap_target
    import csr_file_pkg::*;
(
    input  logic [63:0] i_mtvec,
    input  logic [63:0] i_mepc,
    input  logic [63:0] i_cause,
    input  logic        i_is_mret,
    output logic [63:0] o_target
);
    logic [63:0] w_base;
    logic [63:0] w_offset;

    assign w_base   = {i_mtvec[63:2], 2'b00};
    assign w_offset = {1'b0, i_cause[62:0]} << 2;

    // Select mret return address, vectored interrupt slot or trap base
    always_comb begin
        o_target = w_base;
        if (i_is_mret)
            o_target = i_mepc;
        else if (i_mtvec[1:0] == MTVEC_MODE_VECTORED && i_cause[63])
            o_target = w_base + w_offset;
    end
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr read-modify-write, trap/mret, mcycle, irq pending.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [63:0] HARTID = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] ra,
    output logic [63:0] rd,
    output logic        illegal,
    input  logic [1:0]  csr_op,
    input  logic [11:0] wa,
    input  logic [63:0] wsrc,
    input  logic        trap_valid,
    input  logic [63:0] trap_pc,
    input  logic [63:0] trap_cause,
    input  logic [63:0] trap_tval,
    input  logic        mret_valid,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        sw_irq,
    output logic        int_pending,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output csr_regs_t   regs
);
    mstatus_t    r_mstatus;
    logic [63:0] r_mie, r_mip, r_mtvec, r_mscratch, r_mepc;
    logic [63:0] r_mcause, r_mtval, r_satp, r_mcycle;
    logic        r_redirect_valid;
    logic [63:0] r_redirect_pc;

    csr_regs_t   w_regs;
    csr_op_t     w_op;
    logic [63:0] w_old;
    logic [63:0] w_wdata;
    logic        w_csr_we;
    logic        w_event;
    logic [63:0] w_target;
    logic [63:0] w_mip_next;
    mstatus_t    w_mstatus_trap;
    mstatus_t    w_mstatus_mret;

    // Assemble the architectural view of all CSRs
    always_comb begin
        w_regs.mstatus  = r_mstatus;
        w_regs.mie      = r_mie;
        w_regs.mip      = r_mip;
        w_regs.mtvec    = r_mtvec;
        w_regs.mscratch = r_mscratch;
        w_regs.mepc     = r_mepc;
        w_regs.mcause   = r_mcause;
        w_regs.mtval    = r_mtval;
        w_regs.satp     = r_satp;
        w_regs.mcycle   = r_mcycle;
        w_regs.mhartid  = HARTID;
    end

    assign regs           = w_regs;
    assign rd             = csr_read(w_regs, ra);
    assign illegal        = ~csr_implemented(ra);
    assign int_pending    = r_mstatus.mie & (|(r_mip & r_mie));
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

    assign w_op     = csr_op_t'(csr_op);
    assign w_old    = csr_read(w_regs, wa);
    assign w_event  = trap_valid | mret_valid;
    assign w_csr_we = (w_op != CSR_NONE) && !w_event && csr_implemented(wa);

    // Zicsr write value from old contents and operand
    always_comb begin
        case (w_op)
            CSR_RW:  w_wdata = wsrc;
            CSR_RS:  w_wdata = w_old | wsrc;
            CSR_RC:  w_wdata = w_old & ~wsrc;
            default: w_wdata = w_old;
        endcase
    end

    // Next mip from the interrupt lines and mstatus images for trap/mret
    always_comb begin
        w_mip_next          = '0;
        w_mip_next[IRQ_MEI] = ext_irq;
        w_mip_next[IRQ_MTI] = timer_irq;
        w_mip_next[IRQ_MSI] = sw_irq;

        w_mstatus_trap      = r_mstatus;
        w_mstatus_trap.mpie = r_mstatus.mie;
        w_mstatus_trap.mie  = 1'b0;
        w_mstatus_trap.mpp  = 2'b11;

        w_mstatus_mret      = r_mstatus;
        w_mstatus_mret.mie  = r_mstatus.mpie;
        w_mstatus_mret.mpie = 1'b1;
        w_mstatus_mret.mpp  = 2'b00;
    end

    csr_trap_target u_trap_target (
        .i_mtvec   (r_mtvec),
        .i_mepc    (r_mepc),
        .i_cause   (trap_cause),
        .i_is_mret (!trap_valid),
        .o_target  (w_target)
    );

    // CSR state, mcycle counter and registered redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mstatus        <= '0;
            r_mie            <= '0;
            r_mip            <= '0;
            r_mtvec          <= '0;
            r_mscratch       <= '0;
            r_mepc           <= '0;
            r_mcause         <= '0;
            r_mtval          <= '0;
            r_satp           <= '0;
            r_mcycle         <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_mip            <= w_mip_next;
            r_mcycle         <= r_mcycle + 64'd1;
            r_redirect_valid <= w_event;
            r_redirect_pc    <= w_event ? w_target : '0;
            if (trap_valid) begin
                r_mepc    <= trap_pc;
                r_mcause  <= trap_cause;
                r_mtval   <= trap_tval;
                r_mstatus <= w_mstatus_trap;
            end else if (mret_valid) begin
                r_mstatus <= w_mstatus_mret;
            end else if (w_csr_we) begin
                // A write to mcycle overrides the increment above
                case (wa)
                    CSR_MSTATUS:  r_mstatus  <= mstatus_t'((r_mstatus & ~MSTATUS_WMASK) |
                                                          (w_wdata & MSTATUS_WMASK));
                    CSR_MIE:      r_mie      <= w_wdata;
                    CSR_MTVEC:    r_mtvec    <= {w_wdata[63:2], w_wdata[1] ? 2'b00 : w_wdata[1:0]};
                    CSR_MSCRATCH: r_mscratch <= w_wdata;
                    CSR_MEPC:     r_mepc     <= {w_wdata[63:2], 2'b00};
                    CSR_MCAUSE:   r_mcause   <= w_wdata;
                    CSR_MTVAL:    r_mtval    <= w_wdata;
                    CSR_SATP:     r_satp     <= w_wdata;
                    CSR_MCYCLE:   r_mcycle   <= w_wdata;
                    default:      ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file.
module tb_csr_file;
    import csr_file_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] ra, wa;
    logic [63:0] rd, wsrc;
    logic        illegal;
    logic [1:0]  csr_op;
    logic        trap_valid, mret_valid;
    logic [63:0] trap_pc, trap_cause, trap_tval;
    logic        ext_irq, timer_irq, sw_irq;
    logic        int_pending, redirect_valid;
    logic [63:0] redirect_pc;
    csr_regs_t   regs;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    csr_file #(.HARTID(64'd3)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .illegal(illegal),
        .csr_op(csr_op), .wa(wa), .wsrc(wsrc),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .mret_valid(mret_valid),
        .ext_irq(ext_irq), .timer_irq(timer_irq), .sw_irq(sw_irq),
        .int_pending(int_pending), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .regs(regs)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [1:0] op, input logic [11:0] a, input logic [63:0] v);
        csr_op = op; wa = a; wsrc = v;
        tick();
        csr_op = 2'd0;
    endtask

    initial begin
        reset = 1'b1; ra = CSR_MSTATUS; wa = '0; wsrc = '0; csr_op = 2'd0;
        trap_valid = 1'b0; mret_valid = 1'b0;
        trap_pc = '0; trap_cause = '0; trap_tval = '0;
        ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0;
        #1;
        check("rst_mstatus", rd, 64'h0);
        ra = CSR_MEPC; #1;
        check("rst_mepc", rd, 64'h0);
        ra = CSR_MHARTID; #1;
        check("rst_mhartid", rd, 64'd3);
        check("rst_redirect_valid", {63'h0, redirect_valid}, 64'h0);
        check("rst_redirect_pc", redirect_pc, 64'h0);
        check("rst_int_pending", {63'h0, int_pending}, 64'h0);
        #10 reset = 1'b0;
        ra = CSR_MCYCLE;
        repeat (5) tick();
        check("mcycle_5", rd, 64'd5);

        // Zicsr ops on mscratch; same-cycle read sees old value
        ra = CSR_MSCRATCH; csr_op = 2'd1; wa = CSR_MSCRATCH; wsrc = 64'hDEAD_BEEF; #1;
        check("rw_old_value", rd, 64'h0);
        tick(); csr_op = 2'd0;
        check("rw_mscratch", rd, 64'hDEAD_BEEF);
        csr_write(2'd2, CSR_MSCRATCH, 64'hF0);
        check("rs_mscratch", rd, 64'hDEAD_BEFF);
        csr_write(2'd3, CSR_MSCRATCH, 64'hFF);
        check("rc_mscratch", rd, 64'hDEAD_BE00);

        // Vectored interrupt trap
        csr_write(2'd1, CSR_MTVEC, 64'h8000_0001);
        csr_write(2'd1, CSR_MSTATUS, 64'h8);
        ra = CSR_MSTATUS; #1;
        check("mstatus_mie_set", rd, 64'h8);
        trap_valid = 1'b1; trap_pc = 64'h100;
        trap_cause = 64'h8000_0000_0000_0007; trap_tval = 64'h55;
        tick(); trap_valid = 1'b0;
        check("trap_redirect_valid", {63'h0, redirect_valid}, 64'h1);
        check("trap_redirect_pc", redirect_pc, 64'h8000_001C);
        check("trap_mepc", regs.mepc, 64'h100);
        check("trap_mcause", regs.mcause, 64'h8000_0000_0000_0007);
        check("trap_mtval", regs.mtval, 64'h55);
        check("trap_mstatus", rd, 64'h1880);
        tick();
        check("trap_pulse_end", {63'h0, redirect_valid}, 64'h0);
        check("trap_pc_cleared", redirect_pc, 64'h0);

        // mret
        mret_valid = 1'b1;
        tick(); mret_valid = 1'b0;
        check("mret_redirect_valid", {63'h0, redirect_valid}, 64'h1);
        check("mret_redirect_pc", redirect_pc, 64'h100);
        check("mret_mstatus", rd, 64'h88);
        tick();
        check("mret_pulse_end", {63'h0, redirect_valid}, 64'h0);

        // mtvec reserved mode and mepc alignment
        csr_write(2'd1, CSR_MTVEC, 64'h2002);
        ra = CSR_MTVEC; #1;
        check("mtvec_mode2", rd, 64'h2000);
        csr_write(2'd1, CSR_MEPC, 64'h207);
        ra = CSR_MEPC; #1;
        check("mepc_align", rd, 64'h204);

        // Trap beats mret and CSR write; back-to-back trap follows
        trap_valid = 1'b1; trap_pc = 64'h300; trap_cause = 64'h2; trap_tval = 64'h0;
        mret_valid = 1'b1; csr_op = 2'd1; wa = CSR_MEPC; wsrc = 64'h999;
        tick();
        mret_valid = 1'b0; csr_op = 2'd0;
        check("prio_mepc", regs.mepc, 64'h300);
        check("prio_redirect_pc", redirect_pc, 64'h2000);
        check("prio_mstatus", regs.mstatus, 64'h1880);
        trap_pc = 64'h400; trap_cause = 64'h8000_0000_0000_0003;
        tick(); trap_valid = 1'b0;
        check("b2b_redirect_valid", {63'h0, redirect_valid}, 64'h1);
        check("b2b_redirect_pc", redirect_pc, 64'h2000);
        check("b2b_mepc", regs.mepc, 64'h400);
        check("b2b_mstatus", regs.mstatus, 64'h1800);
        tick();
        check("b2b_pulse_end", {63'h0, redirect_valid}, 64'h0);

        // Read-only, unimplemented and masked writes
        csr_write(2'd1, CSR_MHARTID, 64'h77);
        ra = CSR_MHARTID; #1;
        check("mhartid_ro", rd, 64'd3);
        check("mhartid_legal", {63'h0, illegal}, 64'h0);
        ra = 12'h7FF; #1;
        check("illegal_flag", {63'h0, illegal}, 64'h1);
        check("illegal_rd", rd, 64'h0);
        csr_write(2'd1, CSR_MSTATUS, '1);
        ra = CSR_MSTATUS; #1;
        check("mstatus_wmask", rd, 64'h001C_1888);

        // mcycle wrap
        csr_write(2'd1, CSR_MCYCLE, '1);
        ra = CSR_MCYCLE; #1;
        check("mcycle_load", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("mcycle_wrap", rd, 64'h0);

        // Interrupt pending, one cycle behind the line
        csr_write(2'd1, CSR_MIE, 64'h80);
        csr_write(2'd1, CSR_MSTATUS, 64'h8);
        timer_irq = 1'b1; #1;
        check("irq_not_yet", {63'h0, int_pending}, 64'h0);
        tick();
        check("irq_pending", {63'h0, int_pending}, 64'h1);
        ra = CSR_MIP; #1;
        check("mip_timer", rd, 64'h80);
        timer_irq = 1'b0; ext_irq = 1'b1;
        tick();
        check("irq_masked", {63'h0, int_pending}, 64'h0);
        check("mip_ext", rd, 64'h800);
        ext_irq = 1'b0;

        // Reset during a redirect pulse
        trap_valid = 1'b1; trap_pc = 64'h500; trap_cause = 64'h4;
        tick(); trap_valid = 1'b0;
        check("pre_reset_pulse", {63'h0, redirect_valid}, 64'h1);
        #2 reset = 1'b1; #1;
        check("reset_clears_pulse", {63'h0, redirect_valid}, 64'h0);
        check("reset_clears_pc", redirect_pc, 64'h0);
        ra = CSR_MSCRATCH; #1;
        check("reset_mscratch", rd, 64'h0);
        #10 reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
